// File: rtl/reduce_and_arbiter_if.sv
// Requester/result bundle for reduce_and_arbiter.
// The DUT connects through the slave modport; a requester-side driver uses master.
interface reduce_and_arbiter_if #(
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 8
);
  localparam int IDW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [PORT_NUM-1:0]       req;
  logic [PORT_NUM-1:0]       in_valid;
  logic [PORT_NUM-1:0]       in_last;
  logic [PORT_NUM*WIDTH-1:0] in_data;
  logic [PORT_NUM-1:0]       in_ready;
  logic [PORT_NUM-1:0]       gnt;
  logic                      res_valid;
  logic                      res_ready;
  logic [WIDTH-1:0]          res;
  logic [IDW-1:0]            res_id;
  logic [3:0]                res_beats;

  modport master (
    output req, in_valid, in_last, in_data, res_ready,
    input  in_ready, gnt, res_valid, res, res_id, res_beats
  );

  modport slave (
    input  req, in_valid, in_last, in_data, res_ready,
    output in_ready, gnt, res_valid, res, res_id, res_beats
  );
endinterface

// File: rtl/reduce_and_arbiter.sv
// Arbitrated AND-reduction: one granted requester streams up to 8 beats, result is &(all bits).
// Define REDUCE_AND_RR_ARB_EN for round-robin arbitration; default is fixed lowest-index priority.
module reduce_and_arbiter #(
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  reduce_and_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no grant, waiting for any req
  // BUSY  | grant locked, accepting beats from the granted port
  // OUT   | result presented until res_ready
  localparam int IDW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, OUT} state_e;

  state_e              state_q, state_d;
  logic [PORT_NUM-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]      gidx_q, gidx_d;
  logic                acc_q, acc_d;
  logic [3:0]          cnt_q, cnt_d;

  logic                sel_found;
  logic [IDW-1:0]      sel_idx;
  logic [WIDTH-1:0]    g_data;
  logic                g_valid;
  logic                g_last;

`ifdef REDUCE_AND_RR_ARB_EN
  localparam int SW = IDW + 1;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [PORT_NUM-1:0] req_rot;
  logic [SW-1:0]       rr_sum;

  // Rotate so bit 0 is the pointer position, then map the winner back to a port index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    rr_sum    = '0;
    req_rot   = PORT_NUM'({bus.req, bus.req} >> ptr_q);
    for (int k = 0; k < PORT_NUM; k++) begin
      if (!sel_found && req_rot[k]) begin
        sel_found = 1'b1;
        rr_sum    = {1'b0, ptr_q} + SW'(k);
        if (rr_sum >= SW'(PORT_NUM)) rr_sum = rr_sum - SW'(PORT_NUM);
        sel_idx   = rr_sum[IDW-1:0];
      end
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = PORT_NUM - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(k);
      end
    end
  end
`endif

  assign g_data  = bus.in_data[gidx_q*WIDTH +: WIDTH];
  assign g_valid = bus.in_valid[gidx_q];
  assign g_last  = bus.in_last[gidx_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef REDUCE_AND_RR_ARB_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          gnt_d   = {{(PORT_NUM-1){1'b0}}, 1'b1} << sel_idx;
          gidx_d  = sel_idx;
          acc_d   = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      BUSY: begin
        if (g_valid) begin
          acc_d = acc_q & (&g_data);
          cnt_d = cnt_q + 4'd1;
          if (g_last || cnt_q == 4'd7) state_d = OUT;
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
          gnt_d   = '0;
`ifdef REDUCE_AND_RR_ARB_EN
          ptr_d   = (gidx_q == IDW'(PORT_NUM - 1)) ? '0 : gidx_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      acc_q   <= 1'b1;
      cnt_q   <= 4'd0;
`ifdef REDUCE_AND_RR_ARB_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef REDUCE_AND_RR_ARB_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.in_ready  = (state_q == BUSY) ? gnt_q : '0;
  assign bus.res_valid = (state_q == OUT);
  assign bus.res       = (state_q == OUT) ? {{(WIDTH-1){1'b0}}, acc_q} : '0;
  assign bus.res_id    = (state_q == OUT) ? gidx_q : '0;
  assign bus.res_beats = (state_q == OUT) ? cnt_q : 4'd0;
endmodule

// File: tb/tb_reduce_and_arbiter.sv
// Scoreboard bench for reduce_and_arbiter (PORT_NUM=2, WIDTH=7) with directed beat vectors.
// Expected res_id for the shared-request case depends on REDUCE_AND_RR_ARB_EN.
module tb_reduce_and_arbiter;
  logic clk;
  logic rst_n;

  reduce_and_arbiter_if #(.PORT_NUM(2), .WIDTH(7)) bus ();

  reduce_and_arbiter #(.PORT_NUM(2), .WIDTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] res;
    logic       id;
    logic [3:0] beats;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [6:0] beat_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       32'(bus.gnt),       32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_res"},       32'(bus.res),       32'd0);
    check({tag, "_res_id"},    32'(bus.res_id),    32'd0);
    check({tag, "_res_beats"}, 32'(bus.res_beats), 32'd0);
  endtask

  task automatic wait_grant(input logic [1:0] exp_g, output bit got);
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk); #1;
      if (bus.gnt != 2'b00) got = 1'b1;
    end
    check("grant", 32'(bus.gnt), 32'(exp_g));
  endtask

  // Other port always shows valid/last with zero data; it must be ignored.
  task automatic drive_beat(input int p, input logic [6:0] d, input bit last);
    logic [13:0] dv;
    dv = '0;
    dv[p*7 +: 7] = d;
    bus.in_data  = dv;
    bus.in_valid = 2'b11;
    bus.in_last  = 2'b11;
    bus.in_last[p] = last;
  endtask

  task automatic drive_txn(input int p, input logic [1:0] req_pat, input int last_at,
                           input bit drop_req, input logic [6:0] exp_res, input logic [3:0] exp_beats);
    int   n;
    int   end_beat;
    bit   got;
    exp_t e;
    n = beat_q.size();
    end_beat = (last_at != 0) ? last_at : ((n < 8) ? n : 8);
    e.res = exp_res;
    e.id = p[0];
    e.beats = exp_beats;
    exp_q.push_back(e);
    bus.req = req_pat;
    wait_grant(2'b01 << p, got);
    if (drop_req) bus.req = 2'b00;
    if (got) begin
      for (int i = 0; i < n; i++) begin
        drive_beat(p, beat_q[i], (i + 1) == last_at);
        check("in_ready", 32'(bus.in_ready[p]), 32'(i < end_beat));
        @(posedge clk); #1;
        if (i == end_beat - 1) check("res_valid_latency", 32'(bus.res_valid), 32'd1);
      end
    end
    bus.in_valid = 2'b00;
    bus.in_last  = 2'b00;
    bus.in_data  = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got res=%0h id=%0d beats=%0d expected no result",
                 bus.res, bus.res_id, bus.res_beats);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.res !== mon_e.res || bus.res_id !== mon_e.id || bus.res_beats !== mon_e.beats) begin
          fails++;
          $display("FAIL result: got res=%0h id=%0d beats=%0d expected res=%0h id=%0d beats=%0d",
                   bus.res, bus.res_id, bus.res_beats, mon_e.res, mon_e.id, mon_e.beats);
        end
      end
    end else if (rst_n && !bus.res_valid) begin
      tests++;
      if (bus.res !== 7'd0 || bus.res_id !== 1'b0 || bus.res_beats !== 4'd0) begin
        fails++;
        $display("FAIL idle_outputs: got res=%0h id=%0d beats=%0d expected all 0",
                 bus.res, bus.res_id, bus.res_beats);
      end
    end
  end

  initial begin
    bit got;
    int rr_id[4];
`ifdef REDUCE_AND_RR_ARB_EN
    rr_id = '{0, 1, 0, 1};
`else
    rr_id = '{0, 0, 0, 0};
`endif
    rst_n         = 1'b0;
    bus.req       = 2'b00;
    bus.in_valid  = 2'b00;
    bus.in_last   = 2'b00;
    bus.in_data   = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Three all-ones beats: result 1
    beat_q = '{7'h7F, 7'h7F, 7'h7F};
    drive_txn(0, 2'b01, 3, 1'b1, 7'h01, 4'd3);
    @(posedge clk); #1;

    // Single 7E beat, consumer stalls four cycles
    bus.res_ready = 1'b0;
    beat_q = '{7'h7E};
    drive_txn(0, 2'b01, 1, 1'b1, 7'h00, 4'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_res",   32'(bus.res),       32'd0);
      check("hold_id",    32'(bus.res_id),    32'd0);
      check("hold_beats", 32'(bus.res_beats), 32'd1);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", 32'(bus.res_valid), 32'd0);
    check("post_hs_gnt",   32'(bus.gnt),       32'd0);

    // Ten beats, no last: cut off at 8
    beat_q = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    drive_txn(0, 2'b01, 0, 1'b1, 7'h01, 4'd8);

    // Port 1, one beat with a zero bit
    beat_q = '{7'h7F, 7'h3F, 7'h7F};
    drive_txn(1, 2'b10, 3, 1'b1, 7'h00, 4'd3);

    // Both requesting continuously
    beat_q = '{7'h7F};
    for (int t = 0; t < 4; t++) drive_txn(rr_id[t], 2'b11, 1, 1'b0, 7'h01, 4'd1);
    bus.req = 2'b00;
    @(posedge clk); #1;

    // Reset after two accepted beats discards the transaction
    bus.req = 2'b10;
    wait_grant(2'b10, got);
    bus.req = 2'b00;
    drive_beat(1, 7'h7F, 1'b0);
    @(posedge clk); #1;
    drive_beat(1, 7'h3F, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 2'b00;
    bus.in_last  = 2'b00;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("abort");
    rst_n = 1'b1;
    beat_q = '{7'h7F, 7'h7F};
    drive_txn(1, 2'b10, 2, 1'b1, 7'h01, 4'd2);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reduce_and_arbiter.md
REDUCE_AND_ARBITER -- requirements
Module: reduce_and_arbiter

Interface
REQ-001 The block SHALL have parameter PORT_NUM, default 2, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port req, input, PORT_NUM bits: per-requester access request.
REQ-006 The block SHALL have port in_valid, input, PORT_NUM bits: per-requester operand beat valid.
REQ-007 The block SHALL have port in_last, input, PORT_NUM bits: per-requester final-beat marker.
REQ-008 The block SHALL have port in_data, input, PORT_NUM*WIDTH bits: requester i's operand at bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_ready, output, PORT_NUM bits: beat accept, asserted only for the granted requester in BUSY.
REQ-010 The block SHALL have port gnt, output, PORT_NUM bits: one-hot grant, all-zero in IDLE.
REQ-011 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port res_ready, input, 1 bit: result consumer ready.
REQ-013 The block SHALL have port res, output, WIDTH bits: bit 0 is the AND of all bits of all accepted beats; bits [WIDTH-1:1] are 0.
REQ-014 The block SHALL have port res_id, output, max(1,$clog2(PORT_NUM)) bits: index of the requester owning res.
REQ-015 The block SHALL have port res_beats, output, 4 bits: number of beats reduced (1..8).

Function
REQ-016 The block SHALL implement the states IDLE, BUSY and OUT.
REQ-017 In IDLE with req nonzero, the block SHALL select one requester per REQ-030 or REQ-031, register gnt, load acc=1 and cnt=0, and enter BUSY on the next edge.
REQ-018 In IDLE with req zero, the block SHALL remain in IDLE with gnt=0.
REQ-019 In BUSY, a beat SHALL be accepted when in_valid[g] is high (in_ready[g] is high throughout BUSY); on accept, acc <= acc & (&in_data[g]) and cnt <= cnt+1.
REQ-020 BUSY SHALL transition to OUT on the accept of a beat with in_last[g]=1, or on the 8th accepted beat regardless of in_last.
REQ-021 The grant SHALL remain locked to g for the whole of BUSY and OUT, even if req[g] drops; other requests are held off.
REQ-022 In OUT, the block SHALL hold res_valid=1, res={WIDTH-1 zeros, acc}, res_id=g and res_beats=cnt stable until res_ready is high.
REQ-023 On OUT with res_ready=1, the block SHALL enter IDLE and deassert res_valid and gnt on the next edge.
REQ-024 Latency SHALL be: grant one cycle after req is sampled in IDLE; res_valid one cycle after the final beat is accepted.
REQ-025 With res_ready held high, the minimum IDLE-to-IDLE cycle SHALL be 1 (grant) + N beats + 1 (OUT) cycles.
REQ-026 in_valid or in_last on non-granted ports SHALL be ignored.
REQ-027 Outside OUT, res, res_id and res_beats SHALL be 0.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, gnt=0, in_ready=0, res_valid=0, res=0, res_id=0, res_beats=0, acc=1, cnt=0, and round-robin pointer=0.
REQ-029 A reset asserted in BUSY or OUT SHALL abort the transaction with no result emitted, and beats already accepted SHALL be discarded.

Configuration
REQ-030 With macro REDUCE_AND_RR_ARB_EN defined, arbitration SHALL be round-robin: search starts at the pointer, and the pointer becomes (g+1) mod PORT_NUM on OUT exit.
REQ-031 Without REDUCE_AND_RR_ARB_EN, arbitration SHALL be fixed priority with the lowest index winning, and the block SHALL contain no pointer register.

Verification
REQ-032 Reset, then req=01, 3 beats of data 7F, 7F, 7F with last on the 3rd (WIDTH=7) -> res=01, res_id=0, res_beats=3, one cycle after the 3rd beat.
REQ-033 Single beat 7E with last -> res=00, res_beats=1; hold res_ready=0 for 4 cycles -> outputs stable, then a single-cycle handshake completes.
REQ-034 Send 10 beats of 7F with no last -> OUT after the 8th beat, res_beats=8, in_ready low thereafter.
REQ-035 req=11 held continuously -> with REDUCE_AND_RR_ARB_EN defined, res_id alternates 0,1,0,1; without it, res_id is always 0.
REQ-036 Assert rst_n=0 after the 2nd beat -> all outputs 0 next cycle, no res_valid; a new transaction afterwards gives the correct result.
